// File: rtl/uart_instr_loader.sv
// uart_instr_loader: packs UART bytes (high first) into 16-bit words, writes them to instruction memory.
// Latency: low-byte strobe in cycle N gives o_mem_we in cycle N+1; done follows an IDLE_TIMEOUT gap.
// Backpressure: none, strobes are >= 2 cycles apart; optional HALT finish via UART_LOADER_HALT_DETECT_EN.

module uart_instr_loader #(
  parameter int unsigned START_ADDR   = 1,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned IDLE_TIMEOUT = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_rx_valid,
  input  logic              i_cpu_run,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  output logic [ADDR_W-1:0] o_max_addr,
  output logic              o_transmit_done,
  output logic              o_busy,
  output logic              o_partial_err,
  output logic              o_overflow
);

  localparam int unsigned       CNT_W      = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(IDLE_TIMEOUT);
  localparam logic [ADDR_W-1:0] ADDR_START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_TOP   = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_WR   = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] max_q, max_d;
  logic              full_q, full_d;
  logic              perr_q, perr_d;
  logic              ovf_q, ovf_d;

  // A byte only counts when the CPU is not running; DONE additionally ignores it below.
  logic              byte_ok;
  logic              cnt_last;
  logic [CNT_W-1:0]  cnt_inc;
  logic              halt_hit;

  assign byte_ok  = i_rx_valid && !i_cpu_run;
  assign cnt_last = (cnt_q == CNT_LAST);
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef UART_LOADER_HALT_DETECT_EN
  assign halt_hit = (wdata_q[15:13] == 3'b111);
`else
  assign halt_hit = 1'b0;
`endif

  // Next-state, counter and datapath decisions for the load sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    max_d   = max_q;
    full_d  = full_q;
    perr_d  = perr_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (byte_ok) begin
          hi_d    = i_rx_byte;
          cnt_d   = '0;
          state_d = S_HI;
        end
      end

      S_HI: begin
        if (byte_ok) begin
          wdata_d = {hi_q, i_rx_byte};
          cnt_d   = '0;
          state_d = S_WR;
        end else if (cnt_last) begin
          // Line went quiet with half a word held: finish but flag it.
          perr_d  = 1'b1;
          cnt_d   = CNT_MAX;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_inc;
        end
      end

      S_WR: begin
        if (!full_q) begin
          max_d = addr_q;
          // The pointer freezes on the last address instead of wrapping.
          if (addr_q == ADDR_TOP) begin
            full_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          ovf_d = 1'b1;
        end

        if (!full_q && halt_hit) begin
          state_d = S_DONE;
        end else if (byte_ok) begin
          hi_d    = i_rx_byte;
          cnt_d   = '0;
          state_d = S_HI;
        end else begin
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (byte_ok) begin
          hi_d    = i_rx_byte;
          cnt_d   = '0;
          state_d = S_HI;
        end else if (cnt_last) begin
          cnt_d   = CNT_MAX;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_inc;
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial load and the address pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      wdata_q <= '0;
      addr_q  <= ADDR_START;
      max_q   <= '0;
      full_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      max_q   <= max_d;
      full_q  <= full_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decode directly from registered state; words past the frozen pointer are not written.
  assign o_mem_we        = (state_q == S_WR) && !full_q;
  assign o_mem_addr      = addr_q;
  assign o_mem_wdata     = wdata_q;
  assign o_max_addr      = max_q;
  assign o_transmit_done = (state_q == S_DONE);
  assign o_busy          = (state_q == S_HI) || (state_q == S_WR) || (state_q == S_GAP);
  assign o_partial_err   = perr_q;
  assign o_overflow      = ovf_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// tb_uart_instr_loader: drives byte streams into two loader instances (START_ADDR 1 and 0).
// Expected writes, done timing and flags come from a word-level model of the load rules.
// IDLE_TIMEOUT is scaled down so every scenario completes quickly.

module tb_uart_instr_loader;

  localparam int TO = 200;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_valid = 1'b0;
  logic          cpu_run = 1'b0;

  logic          a_we, a_done, a_busy, a_perr, a_ovf;
  logic [AW-1:0] a_addr, a_max;
  logic [15:0]   a_wdata;
  logic          b_we, b_done, b_busy, b_perr, b_ovf;
  logic [AW-1:0] b_addr, b_max;
  logic [15:0]   b_wdata;

  uart_instr_loader #(.START_ADDR(1), .ADDR_W(AW), .IDLE_TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid), .i_cpu_run(cpu_run),
    .o_mem_we(a_we), .o_mem_addr(a_addr), .o_mem_wdata(a_wdata), .o_max_addr(a_max),
    .o_transmit_done(a_done), .o_busy(a_busy), .o_partial_err(a_perr), .o_overflow(a_ovf)
  );

  uart_instr_loader #(.START_ADDR(0), .ADDR_W(AW), .IDLE_TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid), .i_cpu_run(cpu_run),
    .o_mem_we(b_we), .o_mem_addr(b_addr), .o_mem_wdata(b_wdata), .o_max_addr(b_max),
    .o_transmit_done(b_done), .o_busy(b_busy), .o_partial_err(b_perr), .o_overflow(b_ovf)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  wr_t  qa[$];
  wr_t  qb[$];
  wr_t  wa, wb;
  int   a_done_cyc = -1;
  int   b_done_cyc = -1;
  logic a_done_d = 1'b0;
  logic b_done_d = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every memory write and the first cycle done is seen, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_we === 1'b1) begin
      wa.addr = int'(a_addr); wa.data = int'(a_wdata); wa.cyc = cyc;
      qa.push_back(wa);
    end
    if (b_we === 1'b1) begin
      wb.addr = int'(b_addr); wb.data = int'(b_wdata); wb.cyc = cyc;
      qb.push_back(wb);
    end
    if (a_done === 1'b1 && a_done_d !== 1'b1 && a_done_cyc < 0) a_done_cyc = cyc;
    if (b_done === 1'b1 && b_done_d !== 1'b1 && b_done_cyc < 0) b_done_cyc = cyc;
    a_done_d = a_done;
    b_done_d = b_done;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    qa.delete();
    qb.delete();
    a_done_cyc = -1;
    b_done_cyc = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
  endtask

  // Presents one byte for one cycle; s is the cycle the strobe is high.
  task automatic send_byte(input logic [7:0] b, input int gap, output int s);
    rx_byte = b;
    rx_valid = 1'b1;
    s = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", a_we); end
    checks++; if (a_addr !== 8'd1) begin errors++; $display("FAIL reset_addr: got %0d want 1", a_addr); end
    checks++; if (b_addr !== 8'd0) begin errors++; $display("FAIL reset_addr_b: got %0d want 0", b_addr); end
    checks++; if (a_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0000", a_wdata); end
    checks++; if (a_max !== 8'd0) begin errors++; $display("FAIL reset_max: got %0d want 0", a_max); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", a_done); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", a_perr); end
    checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", a_ovf); end
    rst = 1'b0;
    clear_mon();
    repeat (5) @(negedge clk);
    checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin errors++;
      $display("FAIL reset_quiet: got busy=%b done=%b want 0/0", a_busy, a_done); end
  endtask

  task automatic test_basic();
    logic [7:0] bts [4];
    int         st [4];
    bts[0] = 8'h41; bts[1] = 8'h26; bts[2] = 8'h81; bts[3] = 8'h80;
    do_reset();
    send_byte(bts[0], $urandom_range(3, 8), st[0]);
    send_byte(bts[1], $urandom_range(80, 110), st[1]);
    send_byte(bts[2], $urandom_range(3, 8), st[2]);
    send_byte(bts[3], 2, st[3]);
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", a_busy); end
    // A completed word spends one WR cycle before the gap counter starts.
    wait_until(st[3] + TO + 5);
    checks++;
    if (qa.size() != 2) begin
      errors++; $display("FAIL basic_count: got %0d writes want 2", qa.size());
    end else begin
      checks++; if (qa[0].addr != 1 || qa[0].data != 'h4126 || qa[0].cyc != st[1] + 1) begin errors++;
        $display("FAIL basic_w0: got a=%0d d=%h c=%0d want a=1 d=4126 c=%0d", qa[0].addr, qa[0].data, qa[0].cyc, st[1] + 1); end
      checks++; if (qa[1].addr != 2 || qa[1].data != 'h8180 || qa[1].cyc != st[3] + 1) begin errors++;
        $display("FAIL basic_w1: got a=%0d d=%h c=%0d want a=2 d=8180 c=%0d", qa[1].addr, qa[1].data, qa[1].cyc, st[3] + 1); end
    end
    checks++; if (a_done_cyc != st[3] + TO + 2) begin errors++;
      $display("FAIL basic_done_cyc: got %0d want %0d", a_done_cyc, st[3] + TO + 2); end
    checks++; if (a_max !== 8'd2) begin errors++; $display("FAIL basic_max: got %0d want 2", a_max); end
    checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b want 0", a_perr); end
    checks++; if (a_busy !== 1'b0 || a_done !== 1'b1) begin errors++;
      $display("FAIL basic_end: got busy=%b done=%b want 0/1", a_busy, a_done); end
  endtask

  // Random program of nw words; with halt_end the last word is 0xE000 and no earlier word is a HALT.
  task automatic test_program(input int nw, input bit halt_end);
    logic [7:0] bts[$];
    int         st[$];
    wr_t        exp[$];
    wr_t        e;
    logic [7:0] hi, lo;
    int         s;
    int         done_exp;
    bit         halted;
    do_reset();
    for (int i = 0; i < nw; i++) begin
      hi = 8'($urandom); lo = 8'($urandom);
      if (halt_end) begin
        if (i == nw - 1) begin hi = 8'hE0; lo = 8'h00; end
        else hi[7] = 1'b0;
      end
      bts.push_back(hi); bts.push_back(lo);
    end
    foreach (bts[i]) begin
      send_byte(bts[i], $urandom_range(3, TO / 2), s);
      st.push_back(s);
    end
    halted = 1'b0;
    done_exp = 0;
    for (int w = 0; w < nw; w++) begin
      if (!halted) begin
        e.addr = 1 + w;
        e.data = (int'(bts[2*w]) << 8) | int'(bts[2*w+1]);
        e.cyc  = st[2*w+1] + 1;
        exp.push_back(e);
`ifdef UART_LOADER_HALT_DETECT_EN
        if (((e.data >> 13) & 7) == 7) begin
          halted = 1'b1;
          done_exp = e.cyc + 1;
        end
`endif
      end
    end
    if (!halted) done_exp = st[st.size() - 1] + TO + 2;
    wait_until(done_exp + 4);
    checks++;
    if (qa.size() != exp.size()) begin
      errors++; $display("FAIL prog_count: got %0d writes want %0d", qa.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        checks++;
        if (qa[i].addr != exp[i].addr || qa[i].data != exp[i].data || qa[i].cyc != exp[i].cyc) begin
          errors++;
          $display("FAIL prog_w%0d: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                   qa[i].addr, qa[i].data, qa[i].cyc, exp[i].addr, exp[i].data, exp[i].cyc);
        end
      end
    end
    checks++; if (a_done_cyc != done_exp) begin errors++;
      $display("FAIL prog_done_cyc: got %0d want %0d", a_done_cyc, done_exp); end
    checks++; if (int'(a_max) != exp[exp.size() - 1].addr) begin errors++;
      $display("FAIL prog_max: got %0d want %0d", a_max, exp[exp.size() - 1].addr); end
    checks++; if (a_perr !== 1'b0 || a_busy !== 1'b0) begin errors++;
      $display("FAIL prog_flags: got perr=%b busy=%b want 0/0", a_perr, a_busy); end
  endtask

  task automatic test_partial();
    int st [3];
    do_reset();
    send_byte(8'h41, 4, st[0]);
    send_byte(8'h00, 5, st[1]);
    send_byte(8'h81, 2, st[2]);
    // A lone high byte times out straight from the holding state, with no WR cycle.
    wait_until(st[2] + TO + 5);
    checks++;
    if (qa.size() != 1) begin
      errors++; $display("FAIL partial_count: got %0d writes want 1", qa.size());
    end else begin
      checks++; if (qa[0].addr != 1 || qa[0].data != 'h4100 || qa[0].cyc != st[1] + 1) begin errors++;
        $display("FAIL partial_w0: got a=%0d d=%h c=%0d want a=1 d=4100 c=%0d", qa[0].addr, qa[0].data, qa[0].cyc, st[1] + 1); end
    end
    checks++; if (a_done_cyc != st[2] + TO + 1) begin errors++;
      $display("FAIL partial_done_cyc: got %0d want %0d", a_done_cyc, st[2] + TO + 1); end
    checks++; if (a_perr !== 1'b1) begin errors++; $display("FAIL partial_perr: got %b want 1", a_perr); end
    checks++; if (a_max !== 8'd1) begin errors++; $display("FAIL partial_max: got %0d want 1", a_max); end
    // Bytes after completion are ignored.
    send_byte(8'h22, 3, st[0]);
    send_byte(8'h33, 5, st[1]);
    checks++; if (qa.size() != 1 || a_done !== 1'b1) begin errors++;
      $display("FAIL partial_after_done: got writes=%0d done=%b want 1/1", qa.size(), a_done); end
  endtask

  task automatic test_reset_mid();
    int s0, s1, s2;
    do_reset();
    send_byte(8'h41, 1, s0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    send_byte(8'h41, 3, s1);
    send_byte(8'h00, 6, s2);
    checks++;
    if (qa.size() != 1) begin
      errors++; $display("FAIL rstmid_count: got %0d writes want 1", qa.size());
    end else begin
      checks++; if (qa[0].addr != 1 || qa[0].data != 'h4100 || qa[0].cyc != s2 + 1) begin errors++;
        $display("FAIL rstmid_w0: got a=%0d d=%h c=%0d want a=1 d=4100 c=%0d", qa[0].addr, qa[0].data, qa[0].cyc, s2 + 1); end
    end
  endtask

  task automatic test_cpu_run();
    int s0, s1, s2, s3, s4;
    do_reset();
    cpu_run = 1'b1;
    send_byte(8'h12, 4, s0);
    send_byte(8'h34, 10, s1);
    checks++; if (qa.size() != 0 || a_busy !== 1'b0) begin errors++;
      $display("FAIL cpurun_ignored: got writes=%0d busy=%b want 0/0", qa.size(), a_busy); end
    cpu_run = 1'b0;
    send_byte(8'h56, 5, s2);
    send_byte(8'h78, 50, s3);
    // A byte while the CPU runs must not restart the idle count.
    cpu_run = 1'b1;
    send_byte(8'h9A, 3, s4);
    cpu_run = 1'b0;
    wait_until(s3 + TO + 5);
    checks++;
    if (qa.size() != 1) begin
      errors++; $display("FAIL cpurun_count: got %0d writes want 1", qa.size());
    end else begin
      checks++; if (qa[0].addr != 1 || qa[0].data != 'h5678 || qa[0].cyc != s3 + 1) begin errors++;
        $display("FAIL cpurun_w0: got a=%0d d=%h c=%0d want a=1 d=5678 c=%0d", qa[0].addr, qa[0].data, qa[0].cyc, s3 + 1); end
    end
    checks++; if (a_done_cyc != s3 + TO + 2) begin errors++;
      $display("FAIL cpurun_done_cyc: got %0d want %0d", a_done_cyc, s3 + TO + 2); end
  endtask

  task automatic test_overflow();
    int         dat[$];
    int         st_lo[$];
    logic [7:0] hi, lo;
    int         s;
    int         last_s;
    do_reset();
    for (int w = 0; w < 258; w++) begin
      hi = 8'($urandom) & 8'h7F;
      lo = 8'($urandom);
      dat.push_back((int'(hi) << 8) | int'(lo));
      send_byte(hi, 3, s);
      send_byte(lo, 3, s);
      st_lo.push_back(s);
      if (w == 255) begin
        checks++; if (b_ovf !== 1'b0 || b_max !== 8'd255) begin errors++;
          $display("FAIL ovf_full: got ovf=%b max=%0d want 0/255", b_ovf, b_max); end
      end
    end
    last_s = st_lo[257];
    wait_until(last_s + TO + 5);
    checks++;
    if (qb.size() != 256) begin
      errors++; $display("FAIL ovf_count: got %0d writes want 256", qb.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (qb[i].addr != i || qb[i].data != dat[i] || qb[i].cyc != st_lo[i] + 1) begin
          errors++;
          $display("FAIL ovf_w%0d: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                   qb[i].addr, qb[i].data, qb[i].cyc, i, dat[i], st_lo[i] + 1);
        end
      end
    end
    checks++; if (b_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", b_ovf); end
    checks++; if (b_max !== 8'd255) begin errors++; $display("FAIL ovf_max: got %0d want 255", b_max); end
    checks++; if (b_done_cyc != last_s + TO + 2) begin errors++;
      $display("FAIL ovf_done_cyc: got %0d want %0d", b_done_cyc, last_s + TO + 2); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_program(11, 1'b1);
    for (int r = 0; r < 3; r++) test_program($urandom_range(1, 16), 1'b0);
    test_partial();
    test_reset_mid();
    test_cpu_run();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_instr_loader.md
Name: uart_instr_loader

Overview:
- Sits between the UART byte receiver and instruction memory, on the load path ahead of CPU start.
- Assembles received bytes into 16-bit instruction words, first byte into [15:8] and second into [7:0].
- Writes each word to consecutive instruction-memory addresses from START_ADDR and reports the highest address written.
- Declares the program loaded (o_transmit_done) after an idle gap on the serial line. This is the signal the CPU start logic waits on.

Parameters:
- START_ADDR, 1, address written by the first assembled word.
- ADDR_W, 8, instruction-memory address width.
- IDLE_TIMEOUT, 20000, clk cycles with no i_rx_valid after activity before load is declared complete (roughly 2 byte times at 115200 baud and 100 MHz).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_rx_byte  in  8  byte from the UART receiver.
- i_rx_valid  in  1  one-cycle strobe; i_rx_byte is valid when this is high.
- i_cpu_run  in  1  CPU running; while high, all bytes are ignored.
- o_mem_we  out  1  one-cycle instruction-memory write strobe.
- o_mem_addr  out  ADDR_W  write address.
- o_mem_wdata  out  16  write data.
- o_max_addr  out  ADDR_W  address of the last word written.
- o_transmit_done  out  1  level; load complete.
- o_busy  out  1  high from the first byte until done.
- o_partial_err  out  1  sticky; the load ended holding a lone high byte.
- o_overflow  out  1  sticky; a word arrived after address 2^ADDR_W-1 had been written.

Behaviour:
- Reset values:
  - o_mem_we, o_transmit_done, o_busy, o_partial_err, o_overflow = 0.
  - o_mem_addr = START_ADDR.
  - o_mem_wdata = 0.
  - o_max_addr = 0.
  - FSM = IDLE; idle counter = 0.
- Reset mid-load discards any held byte and the address pointer; the caller must resend the whole program.
- FSM states:
  - IDLE: no byte yet, no timeout running. On a byte: latch it as the high byte, set o_busy, go to HI.
  - HI: high byte held. On a byte: form the word, go to WR. If the counter reaches IDLE_TIMEOUT: set o_partial_err, go to DONE.
  - WR: single cycle. Assert o_mem_we with o_mem_addr and o_mem_wdata stable. Set o_max_addr = o_mem_addr. Then increment o_mem_addr and go to GAP.
  - GAP: between words. On a byte: latch it as the high byte, go to HI. If the counter reaches IDLE_TIMEOUT: go to DONE.
  - DONE: hold o_transmit_done = 1 and o_busy = 0. Ignore all bytes. Only rst leaves this state.
- Latency: low-byte strobe in cycle N gives o_mem_we in cycle N+1.
  - i_rx_valid cannot recur within 2 cycles at any baud rate in use, so WR never collides with a byte.
  - If a byte does arrive during WR, it is still latched as the high byte and the FSM goes to HI.
- Idle counter:
  - Clears on every accepted byte.
  - Counts in HI and GAP; saturates at IDLE_TIMEOUT.
  - The timeout transition occurs on the cycle the count equals IDLE_TIMEOUT-1 with no byte that cycle.
  - A byte arriving in that same cycle wins: the byte is accepted and no timeout occurs.
- Address wrap: after the word at 2^ADDR_W-1 is written, the pointer is frozen.
  - Later complete words are not written (no o_mem_we) and set o_overflow.
  - The load still ends by timeout.
  - o_max_addr stays at 2^ADDR_W-1.
- i_cpu_run = 1: bytes are ignored in all states; the counter and FSM keep running.
- o_mem_addr/o_mem_wdata outside WR: hold their last values; only their values during o_mem_we matter.

Optional Feature:
- Macro: UART_LOADER_HALT_DETECT_EN.
- Defined: a WR whose word has [15:13] = 3'b111 (HALT) writes normally, then goes directly to DONE the next cycle with no timeout wait. Later bytes are ignored.
- Undefined: the HALT opcode is not decoded; the load ends only by timeout.

Test Plan:
- Bytes 0x41,0x26,0x81,0x80 with a 9550-cycle gap -> writes (addr 1, 0x4126) and (addr 2, 0x8180), each o_mem_we one cycle after its low byte. o_transmit_done rises 20000 cycles after the last byte, o_max_addr = 2, o_partial_err = 0.
- 22-byte program ending 0xE0,0x00 with macro undefined -> 11 writes to addrs 1..11, done after timeout, o_max_addr = 11. With macro defined -> done 1 cycle after the write of 0xE000 to addr 11.
- Bytes 0x41,0x00,0x81 then silence -> a single write (addr 1, 0x4100); o_partial_err = 1, o_transmit_done = 1, o_max_addr = 1.
- rst pulsed one cycle after the high byte 0x41, then bytes 0x41,0x00 -> exactly one write, to addr 1 with 0x4100; no stale byte is used.
- i_cpu_run = 1 while sending 0x12,0x34 -> no o_mem_we and o_busy stays 0. After release, 0x56,0x78 -> write (addr 1, 0x5678).
- 256 words at ADDR_W = 8, START_ADDR = 0 -> addrs 0..255 written. Then 2 more words -> no writes, o_overflow = 1, o_max_addr = 255, done after timeout.
